// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with the transmitter),
// frame width and bit-period counter width.
package uart_pkg;

   localparam int BITS  = 8;
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      s_IDLE          = 3'd0,
      s_RX_START_BIT  = 3'd1,
      s_RX_DATA_BITS  = 3'd2,
      s_RX_PARITY_BIT = 3'd3,
      s_RX_STOP_BIT   = 3'd4,
      s_CLEANUP       = 3'd5,
      s_WAIT_IDLE     = 3'd6
   } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-decoder bundle: byte strobe, byte, activity and error pulses.
// The receiver drives through the master modport, the consumer reads via slave.
interface uart_rx_if;
   import uart_pkg::*;

   logic            o_Rx_DV;
   logic [BITS-1:0] o_Rx_Byte;
   logic            o_Rx_Active;
   logic            o_Rx_Frame_Err;
   logic            o_Rx_Parity_Err;

   modport master (
      output o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Rx_Frame_Err, o_Rx_Parity_Err
   );

   modport slave (
      input  o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Rx_Frame_Err, o_Rx_Parity_Err
   );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// is a parameter so idle-high and idle-low lines can both reuse it.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_Async,
   output logic o_Sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_Async;
         r_sync <= r_meta;
      end
   end

   assign o_Sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error detection and
// optional even parity (enabled by defining UART_RX_PARITY_EN).
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic      i_Clock,
   input  logic      i_Rst_n,
   input  logic      i_Rx_Serial,
   uart_rx_if.master rx_if
);

   localparam logic [CNT_W-1:0] C_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] C_BIT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       C_LAST = 3'(BITS - 1);

   logic            w_rx;
   state_t          r_state;
   logic [CNT_W-1:0] r_count;
   logic [2:0]      r_bit_idx;
   logic [BITS-1:0] r_shift;
   logic [BITS-1:0] r_byte;
   logic            r_dv;
   logic            r_active;
   logic            r_frame_err;
`ifdef UART_RX_PARITY_EN
   logic            r_par_bad;
   logic            r_parity_err;
`endif

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_Async (i_Rx_Serial),
      .o_Sync  (w_rx)
   );

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         r_state     <= s_IDLE;
         r_count     <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_byte      <= '0;
         r_dv        <= 1'b0;
         r_active    <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_dv        <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            s_IDLE: begin
               r_count   <= '0;
               r_bit_idx <= '0;
               if (!w_rx)
                  r_state <= s_RX_START_BIT;
            end

            // A start bit that is no longer low at mid-bit is treated as a glitch.
            s_RX_START_BIT: begin
               if (r_count == C_HALF) begin
                  r_count <= '0;
                  if (!w_rx) begin
                     r_active <= 1'b1;
                     r_state  <= s_RX_DATA_BITS;
                  end else begin
                     r_state  <= s_IDLE;
                  end
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end

            s_RX_DATA_BITS: begin
               if (r_count == C_BIT) begin
                  r_count            <= '0;
                  r_shift[r_bit_idx] <= w_rx;
                  if (r_bit_idx == C_LAST) begin
                     r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                     r_state   <= s_RX_PARITY_BIT;
`else
                     r_state   <= s_RX_STOP_BIT;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            s_RX_PARITY_BIT: begin
               if (r_count == C_BIT) begin
                  r_count   <= '0;
                  r_par_bad <= w_rx ^ (^r_shift);
                  r_state   <= s_RX_STOP_BIT;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
`endif

            // A bad stop bit takes priority over a parity mismatch.
            s_RX_STOP_BIT: begin
               if (r_count == C_BIT) begin
                  r_count <= '0;
                  if (w_rx) begin
`ifdef UART_RX_PARITY_EN
                     if (r_par_bad) begin
                        r_parity_err <= 1'b1;
                     end else begin
                        r_byte <= r_shift;
                        r_dv   <= 1'b1;
                     end
`else
                     r_byte <= r_shift;
                     r_dv   <= 1'b1;
`endif
                     r_state <= s_CLEANUP;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= s_WAIT_IDLE;
                  end
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end

            s_WAIT_IDLE: begin
               if (w_rx)
                  r_state <= s_CLEANUP;
            end

            s_CLEANUP: begin
               r_active <= 1'b0;
               r_state  <= s_IDLE;
            end

            default: r_state <= s_IDLE;
         endcase
      end
   end

   assign rx_if.o_Rx_DV        = r_dv;
   assign rx_if.o_Rx_Byte      = r_byte;
   assign rx_if.o_Rx_Active    = r_active;
   assign rx_if.o_Rx_Frame_Err = r_frame_err;
`ifdef UART_RX_PARITY_EN
   assign rx_if.o_Rx_Parity_Err = r_parity_err;
`else
   assign rx_if.o_Rx_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16; parity scenario runs only
// when UART_RX_PARITY_EN is defined for both bench and design.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB = 16;
   // pin edge -> DV cycle: 2 sync + 1 + H(7) + 9*16 + 1 registered output
`ifdef UART_RX_PARITY_EN
   localparam int DV_LAT = 155 + CPB;
`else
   localparam int DV_LAT = 155;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_pin = 1'b1;
   int   cyc = 0;

   uart_rx_if rx_if ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Rx_Serial (rx_pin),
      .rx_if       (rx_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_cmp = 0;
   int         n_err = 0;
   int         start_cyc;
   logic       last_par;
   int         dv_cyc_q[$];
   logic [7:0] dv_byte_q[$];
   int         ferr_cyc_q[$];
   int         perr_count;
   logic       active_seen;

   always @(negedge clk) begin
      if (rx_if.o_Rx_DV === 1'b1) begin
         dv_cyc_q.push_back(cyc);
         dv_byte_q.push_back(rx_if.o_Rx_Byte);
      end
      if (rx_if.o_Rx_Frame_Err === 1'b1) ferr_cyc_q.push_back(cyc);
      if (rx_if.o_Rx_Parity_Err === 1'b1) perr_count++;
      if (rx_if.o_Rx_Active === 1'b1) active_seen = 1'b1;
   end

   task automatic clear_mon();
      dv_cyc_q.delete();
      dv_byte_q.delete();
      ferr_cyc_q.delete();
      perr_count  = 0;
      active_seen = 1'b0;
   endtask

   task automatic set_bits(input logic v, input int n);
      rx_pin = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_v, input logic par_v);
      start_cyc = cyc;
      last_par  = par_v;
      set_bits(1'b0, CPB);
      for (int k = 0; k < 8; k++) set_bits(data[k], CPB);
`ifdef UART_RX_PARITY_EN
      set_bits(par_v, CPB);
`endif
      set_bits(stop_v, CPB);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      rx_pin = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (rx_if.o_Rx_DV !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b want 0", rx_if.o_Rx_DV); end
      n_cmp++; if (rx_if.o_Rx_Byte !== 8'h00) begin n_err++; $display("FAIL reset_byte: got %h want 00", rx_if.o_Rx_Byte); end
      n_cmp++; if (rx_if.o_Rx_Active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", rx_if.o_Rx_Active); end
      n_cmp++; if (rx_if.o_Rx_Frame_Err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", rx_if.o_Rx_Frame_Err); end
      n_cmp++; if (rx_if.o_Rx_Parity_Err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", rx_if.o_Rx_Parity_Err); end
      rst_n = 1'b1;
      set_bits(1'b1, 10);
      $display("test_reset: done");
   endtask

   task automatic test_single_frame();
      clear_mon();
      send_frame(8'hA5, 1'b1, 1'b0);
      set_bits(1'b1, 20);
      n_cmp++; if (dv_cyc_q.size() !== 1) begin n_err++; $display("FAIL single_dv_count: got %0d want 1", dv_cyc_q.size()); end
      if (dv_cyc_q.size() >= 1) begin
         n_cmp++; if (dv_cyc_q[0] !== start_cyc + DV_LAT) begin n_err++; $display("FAIL single_dv_cycle: got %0d want %0d", dv_cyc_q[0], start_cyc + DV_LAT); end
         n_cmp++; if (dv_byte_q[0] !== 8'hA5) begin n_err++; $display("FAIL single_byte: got %h want a5", dv_byte_q[0]); end
      end
      n_cmp++; if (ferr_cyc_q.size() !== 0) begin n_err++; $display("FAIL single_ferr: got %0d want 0", ferr_cyc_q.size()); end
      n_cmp++; if (active_seen !== 1'b1) begin n_err++; $display("FAIL single_active_seen: got %b want 1", active_seen); end
      n_cmp++; if (rx_if.o_Rx_Active !== 1'b0) begin n_err++; $display("FAIL single_active_end: got %b want 0", rx_if.o_Rx_Active); end
      $display("test_single_frame: byte 0xA5 sent at cycle %0d", start_cyc);
   endtask

   task automatic test_back_to_back();
      int s0;
      clear_mon();
      send_frame(8'h00, 1'b1, 1'b0);
      s0 = start_cyc;
      send_frame(8'hFF, 1'b1, 1'b0);
      set_bits(1'b1, 20);
      n_cmp++; if (dv_cyc_q.size() !== 2) begin n_err++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cyc_q.size()); end
      if (dv_cyc_q.size() == 2) begin
         n_cmp++; if (dv_cyc_q[0] !== s0 + DV_LAT) begin n_err++; $display("FAIL b2b_first_cycle: got %0d want %0d", dv_cyc_q[0], s0 + DV_LAT); end
         n_cmp++; if (dv_cyc_q[1] - dv_cyc_q[0] !== 10 * CPB + ((DV_LAT - 155) != 0 ? CPB : 0)) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", dv_cyc_q[1] - dv_cyc_q[0], DV_LAT - 155 + 10 * CPB); end
         n_cmp++; if (dv_byte_q[0] !== 8'h00) begin n_err++; $display("FAIL b2b_byte0: got %h want 00", dv_byte_q[0]); end
         n_cmp++; if (dv_byte_q[1] !== 8'hFF) begin n_err++; $display("FAIL b2b_byte1: got %h want ff", dv_byte_q[1]); end
      end
      $display("test_back_to_back: bytes 0x00,0xFF");
   endtask

   task automatic test_glitch();
      clear_mon();
      set_bits(1'b0, 5);
      set_bits(1'b1, 40);
      n_cmp++; if (dv_cyc_q.size() !== 0) begin n_err++; $display("FAIL glitch_dv: got %0d want 0", dv_cyc_q.size()); end
      n_cmp++; if (ferr_cyc_q.size() !== 0) begin n_err++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cyc_q.size()); end
      n_cmp++; if (active_seen !== 1'b0) begin n_err++; $display("FAIL glitch_active: got %b want 0", active_seen); end
      n_cmp++; if (dut.r_state !== s_IDLE) begin n_err++; $display("FAIL glitch_state: got %0d want %0d", dut.r_state, s_IDLE); end
      $display("test_glitch: 5-cycle low pulse");
   endtask

   task automatic test_framing();
      clear_mon();
      send_frame(8'h3C, 1'b0, 1'b0);
      set_bits(1'b0, 100);
      n_cmp++; if (dut.r_state !== s_WAIT_IDLE) begin n_err++; $display("FAIL frame_wait_state: got %0d want %0d", dut.r_state, s_WAIT_IDLE); end
      set_bits(1'b1, 20);
      n_cmp++; if (ferr_cyc_q.size() !== 1) begin n_err++; $display("FAIL frame_ferr_count: got %0d want 1", ferr_cyc_q.size()); end
      if (ferr_cyc_q.size() >= 1) begin
         n_cmp++; if (ferr_cyc_q[0] !== start_cyc + DV_LAT) begin n_err++; $display("FAIL frame_ferr_cycle: got %0d want %0d", ferr_cyc_q[0], start_cyc + DV_LAT); end
      end
      n_cmp++; if (dv_cyc_q.size() !== 0) begin n_err++; $display("FAIL frame_dv: got %0d want 0", dv_cyc_q.size()); end
      n_cmp++; if (rx_if.o_Rx_Byte !== 8'hFF) begin n_err++; $display("FAIL frame_byte_kept: got %h want ff", rx_if.o_Rx_Byte); end
      clear_mon();
      send_frame(8'h55, 1'b1, 1'b0);
      set_bits(1'b1, 20);
      n_cmp++; if (dv_cyc_q.size() !== 1) begin n_err++; $display("FAIL frame_next_dv: got %0d want 1", dv_cyc_q.size()); end
      n_cmp++; if (rx_if.o_Rx_Byte !== 8'h55) begin n_err++; $display("FAIL frame_next_byte: got %h want 55", rx_if.o_Rx_Byte); end
      $display("test_framing: 0x3C bad stop, then 0x55");
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      d = 8'h81;
      set_bits(1'b0, CPB);
      for (int k = 0; k < 3; k++) set_bits(d[k], CPB);
      rx_pin = d[3];
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      n_cmp++; if (rx_if.o_Rx_Byte !== 8'h00) begin n_err++; $display("FAIL midrst_byte: got %h want 00", rx_if.o_Rx_Byte); end
      n_cmp++; if (rx_if.o_Rx_Active !== 1'b0) begin n_err++; $display("FAIL midrst_active: got %b want 0", rx_if.o_Rx_Active); end
      n_cmp++; if (rx_if.o_Rx_DV !== 1'b0) begin n_err++; $display("FAIL midrst_dv: got %b want 0", rx_if.o_Rx_DV); end
      n_cmp++; if (dut.r_state !== s_IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want %0d", dut.r_state, s_IDLE); end
      repeat (7) @(posedge clk);
      #1;
      for (int k = 4; k < 8; k++) set_bits(d[k], CPB);
`ifdef UART_RX_PARITY_EN
      set_bits(^d, CPB);
`endif
      set_bits(1'b1, 300);
      clear_mon();
      send_frame(8'h42, 1'b1, ^8'h42);
      set_bits(1'b1, 20);
      n_cmp++; if (dv_cyc_q.size() !== 1) begin n_err++; $display("FAIL midrst_next_dv: got %0d want 1", dv_cyc_q.size()); end
      n_cmp++; if (rx_if.o_Rx_Byte !== 8'h42) begin n_err++; $display("FAIL midrst_next_byte: got %h want 42", rx_if.o_Rx_Byte); end
      $display("test_reset_mid_frame: reset in bit 3 of 0x81, then 0x42");
   endtask

   task automatic test_parity();
`ifdef UART_RX_PARITY_EN
      clear_mon();
      send_frame(8'h01, 1'b1, 1'b0);
      set_bits(1'b1, 20);
      n_cmp++; if (perr_count !== 1) begin n_err++; $display("FAIL par_bad_perr: got %0d want 1", perr_count); end
      n_cmp++; if (dv_cyc_q.size() !== 0) begin n_err++; $display("FAIL par_bad_dv: got %0d want 0", dv_cyc_q.size()); end
      n_cmp++; if (rx_if.o_Rx_Byte !== 8'h42) begin n_err++; $display("FAIL par_bad_byte: got %h want 42", rx_if.o_Rx_Byte); end
      clear_mon();
      send_frame(8'h01, 1'b1, 1'b1);
      set_bits(1'b1, 20);
      n_cmp++; if (perr_count !== 0) begin n_err++; $display("FAIL par_ok_perr: got %0d want 0", perr_count); end
      n_cmp++; if (dv_cyc_q.size() !== 1) begin n_err++; $display("FAIL par_ok_dv: got %0d want 1", dv_cyc_q.size()); end
      n_cmp++; if (rx_if.o_Rx_Byte !== 8'h01) begin n_err++; $display("FAIL par_ok_byte: got %h want 01", rx_if.o_Rx_Byte); end
      $display("test_parity: 0x01 with parity 0 then 1");
`else
      clear_mon();
      send_frame(8'h01, 1'b1, 1'b0);
      set_bits(1'b1, 20);
      n_cmp++; if (perr_count !== 0) begin n_err++; $display("FAIL nopar_perr: got %0d want 0", perr_count); end
      n_cmp++; if (rx_if.o_Rx_Byte !== 8'h01) begin n_err++; $display("FAIL nopar_byte: got %h want 01", rx_if.o_Rx_Byte); end
      $display("test_parity: parity disabled, 0x01 received");
`endif
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_glitch();
      test_framing();
      test_reset_mid_frame();
      test_parity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver for the arbiter's serial link: 8N1 frames (optional even parity) at a fixed bit period of CLKS_PER_BIT system clocks. It is the receive end of the link whose transmit end drives idle-high, start-0, LSB-first data, stop-1. It presents each good byte with a one-cycle valid strobe and flags framing and parity errors. It sits between the board RX pin and the arbiter command decoder.

## Interface
- CLKS_PER_BIT, 87, system clocks per bit; legal range 4..65535; 16-bit counter
- i_Clock  in  1  system clock, all logic on rising edge
- i_Rst_n  in  1  synchronous active-low reset
- i_Rx_Serial  in  1  asynchronous serial line, idle high
- o_Rx_DV  out  1  one-cycle pulse: o_Rx_Byte valid
- o_Rx_Byte  out  8  last good byte, held until next good byte
- o_Rx_Active  out  1  high from start-bit validation until return to IDLE
- o_Rx_Frame_Err  out  1  one-cycle pulse: stop bit sampled 0
- o_Rx_Parity_Err  out  1  one-cycle pulse: parity mismatch (only with UART_RX_PARITY_EN)

## Operation
- i_Rx_Serial passes through a 2-flop synchronizer (reset to 1); the FSM sees only the synchronized line.
- H = (CLKS_PER_BIT-1)/2, integer division.
- States: s_IDLE, s_RX_START_BIT, s_RX_DATA_BITS, s_RX_PARITY_BIT (macro only), s_RX_STOP_BIT, s_CLEANUP, s_WAIT_IDLE.
- s_IDLE: counter and bit index at 0. Synced line = 0 -> s_RX_START_BIT.
- s_RX_START_BIT: count to H, then sample. If 0: o_Rx_Active = 1, counter clears, go to s_RX_DATA_BITS. If 1 (glitch): back to s_IDLE, no outputs.
- s_RX_DATA_BITS: each bit waits CLKS_PER_BIT-1 counts, then samples into shift register position bit_index (LSB first). After bit 7 -> parity or stop state.
- s_RX_STOP_BIT: sample after CLKS_PER_BIT-1 counts.
  - Sample 1, no parity error: latch o_Rx_Byte, pulse o_Rx_DV, go to s_CLEANUP.
  - Sample 0: pulse o_Rx_Frame_Err, no DV, o_Rx_Byte unchanged, go to s_WAIT_IDLE.
- s_WAIT_IDLE: stays until synced line = 1, so a held-low break never retriggers; then s_CLEANUP.
- s_CLEANUP: one cycle, o_Rx_Active = 0, then s_IDLE.
- Reset mid-frame: FSM goes to s_IDLE with all outputs at reset values. The next falling edge is treated as a new start bit.

## Timing
- Reset values: o_Rx_DV 0, o_Rx_Byte 8'h00, o_Rx_Active 0, o_Rx_Frame_Err 0, o_Rx_Parity_Err 0, synchronizer 1, state s_IDLE.
- t0 = first cycle the FSM sees the synced line low in s_IDLE. t0 lags the pin edge by 2 cycles.
- Start check at t0+1+H.
- Data bit k sampled at t0+1+H+(k+1)·CLKS_PER_BIT.
- Stop bit sampled at t0+1+H+9·CLKS_PER_BIT, plus CLKS_PER_BIT with parity.
- o_Rx_DV / o_Rx_Frame_Err are high the cycle after the stop sample, exactly one cycle.
- o_Rx_Byte updates in the same cycle o_Rx_DV rises.
- Back-to-back frames (stop immediately followed by start) are received without loss. The start edge may arrive as early as s_CLEANUP's cycle and is detected within one cycle.
- No backpressure. The consumer must take o_Rx_Byte before the next DV, at least 10·CLKS_PER_BIT later.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame carries an even-parity bit after bit 7, sampled in s_RX_PARITY_BIT.
  - Mismatch with valid stop: pulse o_Rx_Parity_Err, suppress o_Rx_DV, leave o_Rx_Byte unchanged.
  - Mismatch with bad stop: o_Rx_Frame_Err only.
- Undefined: no parity state; o_Rx_Parity_Err tied 0; frame is 8N1.

## Structure
- Shared package uart_pkg: state encodings (3-bit localparams, s_ names shared with the transmitter), bit count constant 8, counter width 16.
- Sub-module uart_sync2: 2-flop synchronizer with reset value parameter. It is reused for other asynchronous inputs.

## Test plan
- CLKS_PER_BIT=16, frame 0xA5 -> one DV pulse at the cycle computed in Timing, o_Rx_Byte=0xA5, Frame_Err 0.
- Back-to-back 0x00 then 0xFF with zero idle between frames -> two DV pulses 160 cycles apart, bytes 0x00 then 0xFF.
- Line low 5 cycles then high (CLKS_PER_BIT=16) -> no DV, no error, o_Rx_Active stays 0, FSM back in s_IDLE.
- Frame 0x3C with stop=0, then line held low 100 cycles -> one Frame_Err pulse, no DV, o_Rx_Byte keeps previous value, no new frame until line high; next 0x55 received correctly.
- i_Rst_n low for 1 cycle at data bit 3 of 0x81 -> outputs at reset values; subsequent 0x42 yields DV with 0x42.
- With UART_RX_PARITY_EN, 0x01 with parity bit 0 -> Parity_Err pulse, no DV; with parity bit 1 -> DV, byte 0x01.
